// File: rtl/bt_ctrl_pkg.sv
// Shared definitions for the gate motor controller: FSM state codes, command bytes
// and status characters.
package bt_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_OPENING  = 3'd1,
        ST_CLOSING  = 3'd2,
        ST_DEADTIME = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    localparam logic [7:0] CMD_OPEN  = 8'h4F;
    localparam logic [7:0] CMD_CLOSE = 8'h43;
    localparam logic [7:0] CMD_STOP  = 8'h53;
    localparam logic [7:0] CMD_RESET = 8'h52;

    localparam logic [7:0] STAT_IDLE  = 8'h69;
    localparam logic [7:0] STAT_OPEN  = 8'h6F;
    localparam logic [7:0] STAT_CLOSE = 8'h63;
    localparam logic [7:0] STAT_DEAD  = 8'h64;
    localparam logic [7:0] STAT_FAULT = 8'h66;

    function automatic logic [7:0] status_char(input state_t s);
        case (s)
            ST_OPENING:  status_char = STAT_OPEN;
            ST_CLOSING:  status_char = STAT_CLOSE;
            ST_DEADTIME: status_char = STAT_DEAD;
            ST_FAULT:    status_char = STAT_FAULT;
            default:     status_char = STAT_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/limit_sync.sv
// Two-flop synchronizer for an asynchronous limit-switch input.
module limit_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/bt_gate_motor_ctrl.sv
// UART command decoder and gate motor sequencer with limits, dead time and run timeout.
// Optional status echo to the UART transmitter when STATUS_ECHO_EN is defined.
module bt_gate_motor_ctrl
    import bt_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES  = 500_000_000,
    parameter int DEADTIME_CYCLES = 5_000_000,
    parameter int CNT_W           = 29
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [7:0] RxData,
    input  logic       RxDone,
    input  logic       finalcarrera1,
    input  logic       finalcarrera2,
    output logic       motor1,
    output logic       motor2,
    output logic [2:0] State,
    output logic       Fault,
    output logic [7:0] TxData,
    output logic       TxStart,
    input  logic       TxDone
);

    logic w_lim_open;
    logic w_lim_closed;

    limit_sync u_sync_open (
        .i_clk   (Clk),
        .i_rst_n (Rst_n),
        .i_async (finalcarrera1),
        .o_sync  (w_lim_open)
    );

    limit_sync u_sync_closed (
        .i_clk   (Clk),
        .i_rst_n (Rst_n),
        .i_async (finalcarrera2),
        .o_sync  (w_lim_closed)
    );

    logic [7:0] r_cmd;
    logic       r_cmd_vld;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cmd     <= 8'h00;
            r_cmd_vld <= 1'b0;
        end else begin
            r_cmd_vld <= RxDone;
            if (RxDone) r_cmd <= RxData;
        end
    end

    state_t         r_state, w_next;
    state_t         r_pend, w_pend_next;
    logic [CNT_W-1:0] r_cnt;
    logic           w_cmd_open, w_cmd_close, w_cmd_stop, w_cmd_reset;
    logic           w_both_lim, w_timeout, w_dead_done;

    assign w_cmd_open  = r_cmd_vld && (r_cmd == CMD_OPEN);
    assign w_cmd_close = r_cmd_vld && (r_cmd == CMD_CLOSE);
    assign w_cmd_stop  = r_cmd_vld && (r_cmd == CMD_STOP);
    assign w_cmd_reset = r_cmd_vld && (r_cmd == CMD_RESET);
    assign w_both_lim  = w_lim_open && w_lim_closed;
    assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_dead_done = (r_cnt == CNT_W'(DEADTIME_CYCLES - 1));

    // Priority: double limit, then target limit, then timer expiry, then commands.
    always_comb begin
        w_next      = r_state;
        w_pend_next = r_pend;
        if (r_state != ST_FAULT && w_both_lim) begin
            w_next = ST_FAULT;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_open && !w_lim_open)
                        w_next = ST_OPENING;
                    else if (w_cmd_close && !w_lim_closed)
                        w_next = ST_CLOSING;
                end
                ST_OPENING: begin
                    if (w_lim_open)       w_next = ST_IDLE;
                    else if (w_timeout)   w_next = ST_FAULT;
                    else if (w_cmd_stop)  w_next = ST_IDLE;
                    else if (w_cmd_close) begin
                        w_next      = ST_DEADTIME;
                        w_pend_next = ST_CLOSING;
                    end
                end
                ST_CLOSING: begin
                    if (w_lim_closed)     w_next = ST_IDLE;
                    else if (w_timeout)   w_next = ST_FAULT;
                    else if (w_cmd_stop)  w_next = ST_IDLE;
                    else if (w_cmd_open) begin
                        w_next      = ST_DEADTIME;
                        w_pend_next = ST_OPENING;
                    end
                end
                ST_DEADTIME: begin
                    if (w_dead_done) begin
                        if (r_pend == ST_OPENING)
                            w_next = w_lim_open ? ST_IDLE : ST_OPENING;
                        else
                            w_next = w_lim_closed ? ST_IDLE : ST_CLOSING;
                    end else if (w_cmd_stop) begin
                        w_next = ST_IDLE;
                    end else if (w_cmd_open) begin
                        w_pend_next = ST_OPENING;
                    end else if (w_cmd_close) begin
                        w_pend_next = ST_CLOSING;
                    end
                end
                ST_FAULT: begin
                    if (w_cmd_reset && !w_both_lim) w_next = ST_IDLE;
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
            r_pend  <= ST_IDLE;
        end else begin
            r_state <= w_next;
            r_pend  <= w_pend_next;
        end
    end

    // One counter serves both the run timeout and the reversal dead time.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            r_cnt <= '0;
        else if (w_next != r_state)
            r_cnt <= '0;
        else if (r_state == ST_OPENING || r_state == ST_CLOSING || r_state == ST_DEADTIME)
            r_cnt <= r_cnt + CNT_W'(1);
        else
            r_cnt <= '0;
    end

    assign motor1 = (r_state == ST_OPENING);
    assign motor2 = (r_state == ST_CLOSING);
    assign State  = r_state;
    assign Fault  = (r_state == ST_FAULT);

`ifdef STATUS_ECHO_EN
    logic       r_tx_pend;
    logic [7:0] r_tx_pend_chr;
    logic [7:0] r_tx_data;
    logic       r_tx_busy;
    logic       r_tx_start;

    // A state change loaded in the same cycle as a launch stays pending: latest status wins.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_tx_pend     <= 1'b0;
            r_tx_pend_chr <= 8'h00;
            r_tx_data     <= 8'h00;
            r_tx_busy     <= 1'b0;
            r_tx_start    <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            if (TxDone) r_tx_busy <= 1'b0;
            if (r_tx_pend && !r_tx_busy) begin
                r_tx_start <= 1'b1;
                r_tx_busy  <= 1'b1;
                r_tx_data  <= r_tx_pend_chr;
                r_tx_pend  <= 1'b0;
            end
            if (w_next != r_state) begin
                r_tx_pend     <= 1'b1;
                r_tx_pend_chr <= status_char(w_next);
            end
        end
    end

    assign TxData  = r_tx_data;
    assign TxStart = r_tx_start;
`else
    logic w_unused_txdone;
    assign w_unused_txdone = TxDone;
    assign TxData  = 8'h00;
    assign TxStart = 1'b0;
`endif

endmodule
